paralelo_serial_lane: RTL and testbench
=======================================

// Module: paralelo_serial_lane
// PURPOSE
// - Per-lane parallel-to-serial stage directly downstream of byte_striping in phy_tx.
// - Consumes one striped lane byte (lane_N / valid_NF) and shifts it out MSB-first, 1 bit/clk_8f.
// - Sends a COM training burst after reset; sends IDLE when no valid byte is offered.
// - One instance per lane; the serial output feeds the channel/serial link model.
// PARAMETERS
// - COM_COUNT  4      number of COM bytes sent after reset before ACTIVE (1..15)
// - COM_BYTE   8'hBC  training/alignment symbol
// - IDLE_BYTE  8'h7C  filler symbol sent when valid_in==0 in ACTIVE
// PORTS
// - clk_8f     in   1  serial bit clock; all state on posedge
// - reset      in   1  asynchronous, active-low reset
// - valid_in   in   1  lane byte valid (valid_NF of byte_striping); held stable across the byte slot
// - data_in    in   8  lane byte (lane_N of byte_striping); held stable across the byte slot
// - data_out   out  1  serial bit, MSB first, driven straight from shift_reg[7]
// - byte_start out  1  1 on the cycle data_out carries bit 7 of a freshly loaded byte
// - load_ack   out  1  1 on the cycle data_in was accepted (ACTIVE and valid_in==1)
// - sync_done  out  1  1 once state==ACTIVE; held until reset
// BEHAVIOUR
// - reset==0 (async): state=SYNC, bit_cnt=3'd7, com_cnt=0, shift_reg=8'h00; outputs data_out=0,
//   byte_start=0, load_ack=0, sync_done=0. Asserting reset mid-byte aborts the byte immediately.
// - bit_cnt: 3-bit, increments every clk_8f edge, wraps 7->0. Load edge = edge where bit_cnt==7.
// - Load edge: shift_reg <= next_byte; byte_start<=1. Other edges: shift_reg <= {shift_reg[6:0],1'b0},
//   byte_start<=0. So byte loaded at edge E drives bit7 after E ... bit0 after E+7; next load at E+8.
// - First load edge is the first clk_8f edge after reset release (bit_cnt resets to 7).
// - next_byte by state, evaluated on load edge:
//   - SYNC: COM_BYTE; com_cnt<=com_cnt+1; when com_cnt==COM_COUNT-1 -> state<=ACTIVE.
//   - ACTIVE: valid_in ? data_in : IDLE_BYTE.
// - valid_in/data_in sampled ONLY on load edges; changes between load edges are ignored.
// - valid_in==1 during SYNC: byte dropped, load_ack stays 0 (upstream must wait for sync_done).
// - load_ack<=1 on load edge iff state==ACTIVE && valid_in==1 (state before the edge); else 0.
// - sync_done<=1 on the load edge that first sends from ACTIVE (i.e. with the first post-COM byte);
//   no return to SYNC except via reset.
// - Latency: data_in sampled at load edge E -> its MSB on data_out in cycle after E, LSB after E+7.
// - Back-to-back valid bytes: no gaps, 8 cycles each; valid_in drop -> IDLE_BYTE from next slot.
// - com_cnt width 4 bits; saturates (not incremented) in ACTIVE.
// STRUCTURE
// - Shared package phy_pkg: COM_BYTE/IDLE_BYTE constants, state enum {SYNC, ACTIVE}, shared with
//   the RX serial-to-parallel block that searches for COM alignment.
// - Single module; no sub-module. Optional: bit_cnt/com_cnt may be a local counter, not a separate file.
// - Purely synchronous to clk_8f apart from async reset; no combinational path from inputs to data_out.
// TESTING
// - Reset release, valid_in=0 -> 4 x 8'hBC (1011_1100 MSB first) then 8'h7C repeating; sync_done
//   rises with first 7C byte; byte_start every 8 cycles, first 1 cycle after reset release.
// - valid_in=1, data_in=8'hA5 during SYNC -> not transmitted, load_ack=0; same at ACTIVE -> bits
//   1,0,1,0,0,1,0,1 on data_out, load_ack=1 for exactly one cycle at that load edge.
// - Back-to-back 8'hFF, 8'h00, 8'h3C, valid_in=1 -> 24 contiguous bits, no IDLE, 3 load_ack pulses.
// - data_in changed from 8'h11 to 8'h22 mid-slot (bit_cnt=3) -> serialized byte stays 8'h11; 8'h22
//   only if still present at next load edge.
// - reset asserted at bit_cnt=4 of 8'hA5 -> data_out=0, sync_done=0 immediately (async); after
//   release the COM burst restarts from com_cnt=0.
// - COM_COUNT=1 override -> single 8'hBC, then ACTIVE on the second load edge.

Source files
------------

// File: rtl/phy_pkg.sv
// rtl/phy_pkg.sv - shared PHY lane symbols and lane state encoding
package phy_pkg;

  localparam logic [7:0] COM_SYMBOL  = 8'hBC;
  localparam logic [7:0] IDLE_SYMBOL = 8'h7C;
  localparam int         COM_COUNT_DEFAULT = 4;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } lane_state_t;

endpackage

// File: rtl/paralelo_serial_lane.sv
// rtl/paralelo_serial_lane.sv - per-lane MSB-first serializer with COM training burst
module paralelo_serial_lane
  import phy_pkg::*;
#(
  parameter int         COM_COUNT = COM_COUNT_DEFAULT,
  parameter logic [7:0] COM_BYTE  = COM_SYMBOL,
  parameter logic [7:0] IDLE_BYTE = IDLE_SYMBOL
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       valid_in,
  input  logic [7:0] data_in,
  output logic       data_out,
  output logic       byte_start,
  output logic       load_ack,
  output logic       sync_done
);

  localparam logic [3:0] COM_LAST = 4'(COM_COUNT - 1);

  lane_state_t state, state_next;
  logic [2:0]  bit_cnt;
  logic [3:0]  com_cnt, com_cnt_next;
  logic [7:0]  shift_reg;
  logic [7:0]  next_byte;
  logic        load;
  logic        load_ack_next;
  logic        sync_done_next;

  // Inputs are only looked at on the load edge, so data_in may wander mid-slot.
  assign load     = (bit_cnt == 3'd7);
  assign data_out = shift_reg[7];

  always_comb begin
    state_next     = state;
    com_cnt_next   = com_cnt;
    next_byte      = COM_BYTE;
    load_ack_next  = 1'b0;
    sync_done_next = sync_done;
    case (state)
      SYNC: begin
        next_byte = COM_BYTE;
        if (load) begin
          com_cnt_next = com_cnt + 4'd1;
          if (com_cnt == COM_LAST) begin
            state_next = ACTIVE;
          end
        end
      end
      ACTIVE: begin
        next_byte = valid_in ? data_in : IDLE_BYTE;
        if (load) begin
          load_ack_next  = valid_in;
          sync_done_next = 1'b1;
        end
      end
      default: begin
        state_next = SYNC;
      end
    endcase
  end

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      state      <= SYNC;
      bit_cnt    <= 3'd7;
      com_cnt    <= 4'd0;
      shift_reg  <= 8'h00;
      byte_start <= 1'b0;
      load_ack   <= 1'b0;
      sync_done  <= 1'b0;
    end else begin
      state      <= state_next;
      bit_cnt    <= bit_cnt + 3'd1;
      com_cnt    <= com_cnt_next;
      shift_reg  <= load ? next_byte : {shift_reg[6:0], 1'b0};
      byte_start <= load;
      load_ack   <= load_ack_next;
      sync_done  <= sync_done_next;
    end
  end

endmodule

// File: tb/tb_paralelo_serial_lane.sv
// tb/tb_paralelo_serial_lane.sv - scoreboard bench for paralelo_serial_lane
module tb_paralelo_serial_lane;

  typedef struct packed {
    logic [7:0] b;
    logic       ack;
    logic       sd;
  } exp_t;

  logic       clk_8f;
  logic       reset;
  logic       valid_in;
  logic [7:0] data_in;
  logic       data_out0, byte_start0, load_ack0, sync_done0;
  logic       data_out1, byte_start1, load_ack1, sync_done1;

  exp_t q0[$];
  exp_t q1[$];
  int   passed;
  int   total;
  int   slot_n;
  logic mon_en;

  paralelo_serial_lane dut0 (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .data_out  (data_out0),
    .byte_start(byte_start0),
    .load_ack  (load_ack0),
    .sync_done (sync_done0)
  );

  paralelo_serial_lane #(.COM_COUNT(1)) dut1 (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .valid_in  (1'b0),
    .data_in   (8'h00),
    .data_out  (data_out1),
    .byte_start(byte_start1),
    .load_ack  (load_ack1),
    .sync_done (sync_done1)
  );

  initial clk_8f = 1'b0;
  always #5 clk_8f = ~clk_8f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Monitor: assemble 8 bits starting at byte_start, then pop and compare.
  logic [7:0] sh[2];
  int         cnt[2];
  logic       ack_s[2];
  logic       sd_s[2];
  int         extra[2];

  always @(negedge clk_8f) begin
    if (!reset || !mon_en) begin
      for (int k = 0; k < 2; k++) begin
        cnt[k] = 0;
        extra[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic bs, dout, la, sdn, empty;
        exp_t e;
        bs   = (k == 0) ? byte_start0 : byte_start1;
        dout = (k == 0) ? data_out0   : data_out1;
        la   = (k == 0) ? load_ack0   : load_ack1;
        sdn  = (k == 0) ? sync_done0  : sync_done1;
        if (bs) begin
          if (cnt[k] != 0) chk($sformatf("lane%0d_start_mid_byte", k), 32'(cnt[k]), 32'd0);
          sh[k] = {7'd0, dout};
          cnt[k] = 1;
          ack_s[k] = la;
          sd_s[k] = sdn;
          extra[k] = 0;
        end else if (cnt[k] > 0) begin
          sh[k] = {sh[k][6:0], dout};
          if (la) extra[k]++;
          cnt[k]++;
          if (cnt[k] == 8) begin
            cnt[k] = 0;
            empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
              chk($sformatf("lane%0d_unexpected_byte", k), {24'd0, sh[k]}, 32'hFFFF_FFFF);
            end else begin
              e = (k == 0) ? q0.pop_front() : q1.pop_front();
              chk($sformatf("lane%0d_byte", k), {24'd0, sh[k]}, {24'd0, e.b});
              chk($sformatf("lane%0d_ack_sync_extra", k),
                  {16'd0, 7'd0, ack_s[k], 7'd0, sd_s[k]} | (32'(extra[k]) << 24),
                  {16'd0, 7'd0, e.ack, 7'd0, e.sd});
            end
          end
        end
      end
    end
  end

  task automatic slot(input logic v, input logic [7:0] d, input logic [7:0] eb,
                      input logic ea, input logic es,
                      input logic mid_en, input logic [7:0] mid_d);
    valid_in = v;
    data_in  = d;
    q0.push_back({eb, ea, es});
    q1.push_back((slot_n == 0) ? {8'hBC, 1'b0, 1'b0} : {8'h7C, 1'b0, 1'b1});
    slot_n++;
    repeat (4) @(negedge clk_8f);
    if (mid_en) data_in = mid_d;
    repeat (4) @(negedge clk_8f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    passed = 0;
    total = 0;
    slot_n = 0;
    mon_en = 1'b0;
    reset = 1'b0;
    valid_in = 1'b0;
    data_in = 8'h00;
    repeat (3) @(negedge clk_8f);
    chk("rst_data_out", {31'd0, data_out0}, 32'd0);
    chk("rst_byte_start", {31'd0, byte_start0}, 32'd0);
    chk("rst_load_ack", {31'd0, load_ack0}, 32'd0);
    chk("rst_sync_done", {31'd0, sync_done0}, 32'd0);

    reset = 1'b1;
    slot_n = 0;
    mon_en = 1'b1;
    slot(1'b0, 8'h00, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00);
    slot(1'b0, 8'h00, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00);
    slot(1'b1, 8'hA5, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00);
    slot(1'b1, 8'hA5, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00);
    slot(1'b0, 8'h00, 8'h7C, 1'b0, 1'b1, 1'b0, 8'h00);
    slot(1'b1, 8'hA5, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00);
    slot(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00);
    slot(1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
    slot(1'b1, 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h00);
    slot(1'b0, 8'h00, 8'h7C, 1'b0, 1'b1, 1'b0, 8'h00);
    slot(1'b1, 8'h11, 8'h11, 1'b1, 1'b1, 1'b1, 8'h22);
    slot(1'b1, 8'h22, 8'h22, 1'b1, 1'b1, 1'b0, 8'h00);
    slot(1'b0, 8'h00, 8'h7C, 1'b0, 1'b1, 1'b0, 8'h00);

    // Abort an A5 byte at bit_cnt=4 with an asynchronous reset.
    valid_in = 1'b1;
    data_in = 8'hA5;
    repeat (5) @(negedge clk_8f);
    #2;
    reset = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("async_rst_data_out", {31'd0, data_out0}, 32'd0);
    chk("async_rst_sync_done", {31'd0, sync_done0}, 32'd0);
    chk("async_rst_sync_done_c1", {31'd0, sync_done1}, 32'd0);
    repeat (2) @(negedge clk_8f);
    valid_in = 1'b0;
    reset = 1'b1;
    slot_n = 0;
    slot(1'b0, 8'h00, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00);
    slot(1'b0, 8'h00, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00);
    slot(1'b0, 8'h00, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00);
    slot(1'b0, 8'h00, 8'hBC, 1'b0, 1'b0, 1'b0, 8'h00);
    slot(1'b0, 8'h00, 8'h7C, 1'b0, 1'b1, 1'b0, 8'h00);
    slot(1'b1, 8'hA5, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00);

    @(posedge clk_8f);
    mon_en = 1'b0;
    chk("lane0_queue_drained", 32'(q0.size()), 32'd0);
    chk("lane1_queue_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
